// File: rtl/spi_dac_pkg.sv
// spi_dac_pkg: shared state encoding, frame geometry and frame builder for the MCP49x2 streaming driver.
package spi_dac_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SCK_LO, SCK_HI, GAP, LDAC} state_t;

    localparam int FRAME_W     = 16;
    localparam int DAC_FIELD_W = 12;
    localparam int AB_BIT      = 15;
    localparam int BUF_BIT     = 14;
    localparam int GA_BIT      = 13;
    localparam int SHDN_BIT    = 12;

    function automatic logic [FRAME_W-1:0] make_frame(
        input logic                   ab,
        input logic                   buffered,
        input logic                   gain_1x,
        input logic                   active,
        input logic [DAC_FIELD_W-1:0] field
    );
        logic [FRAME_W-1:0] f;
        f                  = '0;
        f[AB_BIT]          = ab;
        f[BUF_BIT]         = buffered;
        f[GA_BIT]          = gain_1x;
        f[SHDN_BIT]        = active;
        f[DAC_FIELD_W-1:0] = field;
        return f;
    endfunction

endpackage

// File: rtl/spi_dac_fifo.sv
// spi_dac_fifo: synchronous FIFO holding {last, ch, data} words ahead of the SPI serialiser.
module spi_dac_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rp];
    // A push into a full FIFO is refused even when a pop happens the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/spi_dac_stream.sv
// spi_dac_stream: streams (channel, sample) words as 16-bit MCP49x2 write frames over shared SCK/SDI.
// Define SPI_DAC_LDAC_EN to add the ldac_n port and a latch pulse after each frame marked s_last.
module spi_dac_stream
    import spi_dac_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int NUM_CH     = 2,
    parameter int CLK_DIV    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2,
    parameter bit GAIN_1X    = 1'b1,
    parameter bit BUFFERED   = 1'b1,
    parameter bit ACTIVE     = 1'b1,
    parameter int LDAC_W     = 2,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int NCHIP     = NUM_CH / 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CH_W-1:0]   s_ch,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [NCHIP-1:0]  cs_n,
    output logic              sck,
    output logic              sdi,
`ifdef SPI_DAC_LDAC_EN
    output logic              ldac_n,
`endif
    output logic              busy,
    output logic              err_ch
);

    localparam int FW      = 1 + CH_W + DATA_W;
    localparam int DIV_GAP = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
    localparam int CNT_MAX = DIV_GAP > LDAC_W ? DIV_GAP : LDAC_W;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_bits;
    logic [FRAME_W-1:0] r_frame;
    logic [NCHIP-1:0]   r_cs_n;
    logic               r_sck;
    logic               r_bad;
    logic               r_err;

    logic [FW-1:0]          w_q;
    logic                   w_full;
    logic                   w_empty;
    logic [AW:0]            w_count;
    logic [CH_W-1:0]        w_ch;
    logic [DATA_W-1:0]      w_data;
    logic [DAC_FIELD_W-1:0] w_field;
    logic                   w_bad;
    logic                   w_gap_done;
    logic                   w_pop;

    spi_dac_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (s_valid && s_ready),
        .i_data  ({s_last, s_ch, s_data}),
        .i_pop   (w_pop),
        .o_data  (w_q),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_ch    = w_q[DATA_W +: CH_W];
    assign w_data  = w_q[DATA_W-1:0];
    assign w_field = DAC_FIELD_W'(w_data) << (DAC_FIELD_W - DATA_W);
    assign w_bad   = {1'b0, w_ch} >= (CH_W+1)'(NUM_CH);

`ifdef SPI_DAC_LDAC_EN
    logic r_last;
    logic r_ldac_n;
    assign ldac_n     = r_ldac_n;
    // A point-final frame must run its LDAC pulse before the next frame may start.
    assign w_gap_done = r_state == GAP && r_cnt == '0 && !r_last;
`else
    logic w_unused_last;
    assign w_unused_last = w_q[FW-1];
    assign w_gap_done    = r_state == GAP && r_cnt == '0;
`endif

    assign w_pop   = !w_empty && (r_state == IDLE || w_gap_done);
    assign s_ready = !reset && !w_full;
    assign cs_n    = r_cs_n;
    assign sck     = r_sck;
    assign sdi     = r_frame[FRAME_W-1];
    assign busy    = w_count != '0 || r_state != IDLE;
    assign err_ch  = r_err;

    // LOAD doubles as the first low half-period of bit 15, so cs_n low lasts exactly 32*CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bits   <= '0;
            r_frame  <= '0;
            r_cs_n   <= '1;
            r_sck    <= 1'b0;
            r_bad    <= 1'b0;
            r_err    <= 1'b0;
`ifdef SPI_DAC_LDAC_EN
            r_last   <= 1'b0;
            r_ldac_n <= 1'b1;
`endif
        end else if (w_pop) begin
            r_state <= LOAD;
            r_cnt   <= CW'(CLK_DIV - 1);
            r_bits  <= 4'(FRAME_W - 1);
            r_frame <= w_bad ? '0 : make_frame(w_ch[0], BUFFERED, GAIN_1X, ACTIVE, w_field);
            r_cs_n  <= w_bad ? '1 : ~(NCHIP'(1) << (w_ch >> 1));
            r_bad   <= w_bad;
            r_err   <= r_err | w_bad;
`ifdef SPI_DAC_LDAC_EN
            r_last  <= w_q[FW-1];
`endif
        end else begin
            case (r_state)
                LOAD, SCK_LO:
                    if (r_bad) r_state <= IDLE;
                    else if (r_cnt != '0) begin
                        r_state <= SCK_LO;
                        r_cnt   <= r_cnt - 1'b1;
                    end else begin
                        r_state <= SCK_HI;
                        r_sck   <= 1'b1;
                        r_cnt   <= CW'(CLK_DIV - 1);
                    end
                SCK_HI:
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else begin
                        r_sck   <= 1'b0;
                        r_frame <= r_frame << 1;
                        if (r_bits == '0) begin
                            r_state <= GAP;
                            r_cs_n  <= '1;
                            r_cnt   <= CW'(CS_GAP - 1);
                        end else begin
                            r_state <= SCK_LO;
                            r_bits  <= r_bits - 1'b1;
                            r_cnt   <= CW'(CLK_DIV - 1);
                        end
                    end
                GAP:
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
`ifdef SPI_DAC_LDAC_EN
                    else if (r_last) begin
                        r_state  <= LDAC;
                        r_ldac_n <= 1'b0;
                        r_cnt    <= CW'(LDAC_W - 1);
                    end
`endif
                    else r_state <= IDLE;
`ifdef SPI_DAC_LDAC_EN
                LDAC:
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else begin
                        r_ldac_n <= 1'b1;
                        r_state  <= IDLE;
                    end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_stream.sv
// tb_spi_dac_stream: random and directed stimulus; a bus monitor decodes SPI frames and matches them
// against a queue of expected writes computed from the DAC frame format.
module tb_spi_dac_stream;

    localparam int DATA_W = 12, NUM_CH = 6, CLK_DIV = 2, CS_GAP = 2, LDAC_W = 2;

    typedef struct {int csn; int word;} exp_t;

    logic clk = 1'b0, reset = 1'b1;
    logic s_valid = 1'b0, s_last = 1'b0, s_ready, sck, sdi, busy, err_ch;
    logic [2:0] s_ch = '0, cs_n;
    logic [11:0] s_data = '0;
    logic b_valid = 1'b0, b_last = 1'b0, b_ready, b_sck, b_sdi, b_busy, b_err;
    logic [0:0] b_ch = '0, b_cs_n;
    logic [9:0] b_data = '0;
`ifdef SPI_DAC_LDAC_EN
    logic ldac_n, b_ldac_n;
    int lc = 0, pulses = 0, last_w = 0;
`endif

    int checks = 0, failures = 0;
    exp_t exp_q[$];
    exp_t m_e;
    bit exp_err = 0;
    int nb = 0, lowc = 0, hic = 0, last_gap = 0, frames = 0;
    bit cs_bad = 0, psck = 0;
    logic [2:0] pcs = '1, fcs = '1;
    logic [15:0] sh = '0;

    always #5 clk = ~clk;

    spi_dac_stream #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(4),
                     .CS_GAP(CS_GAP), .LDAC_W(LDAC_W)) u_dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch),
        .s_data(s_data), .s_last(s_last), .cs_n(cs_n), .sck(sck), .sdi(sdi),
`ifdef SPI_DAC_LDAC_EN
        .ldac_n(ldac_n),
`endif
        .busy(busy), .err_ch(err_ch)
    );

    spi_dac_stream #(.DATA_W(10), .NUM_CH(2), .CLK_DIV(1), .FIFO_DEPTH(4), .CS_GAP(2)) u_dut10 (
        .clk(clk), .reset(reset), .s_valid(b_valid), .s_ready(b_ready), .s_ch(b_ch),
        .s_data(b_data), .s_last(b_last), .cs_n(b_cs_n), .sck(b_sck), .sdi(b_sdi),
`ifdef SPI_DAC_LDAC_EN
        .ldac_n(b_ldac_n),
`endif
        .busy(b_busy), .err_ch(b_err)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected write: A/B from ch bit 0, BUF/GA/SHDN all set, sample left-justified in 12 bits.
    task automatic push(input int ch, input int data, input bit last);
        int t = 0;
        @(negedge clk);
        s_valid = 1'b1; s_ch = 3'(ch); s_data = 12'(data); s_last = last;
        while (!s_ready && t < 2000) begin @(negedge clk); t++; end
        chk("push_accept", s_ready, 1);
        if (ch < NUM_CH) exp_q.push_back('{7 ^ (1 << (ch / 2)), ((ch % 2) << 15) | (7 << 12) | ((data % 4096) << (12 - DATA_W))});
        else exp_err = 1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end while (busy && t < 5000);
        chk("idle", busy, 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            nb = 0; lowc = 0; hic = 0; pcs = '1; psck = 0; cs_bad = 0;
        end else begin
            if (cs_n != 3'b111) begin
                if (pcs == 3'b111) begin last_gap = hic; lowc = 0; nb = 0; fcs = cs_n; cs_bad = 0; end
                lowc++;
                if (cs_n != fcs) cs_bad = 1;
                if (sck && !psck) begin sh = {sh[14:0], sdi}; nb++; end
            end else if (pcs != 3'b111) begin
                frames++;
                hic = 1;
                chk("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    chk("frame_word", sh, m_e.word);
                    chk("frame_cs", fcs, m_e.csn);
                    chk("frame_cs_stable", cs_bad, 0);
                    chk("frame_bits", nb, 16);
                    chk("frame_len", lowc, 32 * CLK_DIV);
                end
            end else hic++;
            pcs = cs_n; psck = sck;
        end
    end

`ifdef SPI_DAC_LDAC_EN
    always @(negedge clk) begin
        if (reset) lc = 0;
        else if (!ldac_n) lc++;
        else if (lc != 0) begin pulses++; last_w = lc; lc = 0; end
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, f0, cnt;
        logic [15:0] bsh;
        bit bps;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 3'b111);
        chk("rst_sck", sck, 0);
        chk("rst_sdi", sdi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_ch, 0);
        chk("rst_ready", s_ready, 0);
`ifdef SPI_DAC_LDAC_EN
        chk("rst_ldac", ldac_n, 1);
        chk("dw10_ldac_idle", b_ldac_n, 1);
`endif
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", s_ready, 1);
        chk("dw10_ready", b_ready, 1);

        // 10-bit sample, left-justified: 3FF on ch0 gives 7FFC, 32 low cycles at CLK_DIV=1.
        b_valid = 1'b1; b_ch = 1'b0; b_data = 10'h3FF;
        @(posedge clk); #1 b_valid = 1'b0;
        t = 0;
        while (b_cs_n !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        bsh = '0; bps = 0; cnt = 0;
        while (b_cs_n === 1'b0 && cnt < 200) begin
            if (b_sck && !bps) bsh = {bsh[14:0], b_sdi};
            bps = b_sck; cnt++;
            @(negedge clk);
        end
        chk("dw10_word", bsh, 16'h7FFC);
        chk("dw10_len", cnt, 32);

        // Latency from push into an empty FIFO to cs_n fall and first SCK rise.
        wait_idle();
        push(1, 12'hABC, 0);
        chk("lat_cs_pre", cs_n, 3'b111);
        @(posedge clk); #1;
        chk("lat_cs", cs_n, 3'b110);
        cnt = 0;
        while (!sck && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("lat_sck", cnt, CLK_DIV);
        wait_idle();
        chk("dw10_idle", b_busy, 0);
        chk("dw10_err", b_err, 0);

        // Two channels of chip 1 back-to-back: separated by exactly CS_GAP high cycles.
        push(2, 12'h123, 0);
        push(3, 12'hFED, 0);
        wait_idle();
        chk("gap_b2b", last_gap, CS_GAP);

        // Five words while busy: FIFO full with four held, then order kept.
        for (int i = 0; i < 5; i++) push(i, $urandom_range(0, 4095), 0);
        @(negedge clk);
        chk("full_ready", s_ready, 0);
        chk("full_busy", busy, 1);
        push(5, 12'h5A5, 0);
        wait_idle();

        // Out-of-range channel: accepted, sticky error, no frame on the bus.
        f0 = frames;
        push(7, 12'h777, 0);
        wait_idle();
        repeat (10) @(negedge clk);
        chk("err_ch", err_ch, 1);
        chk("err_no_frame", frames, f0);

`ifdef SPI_DAC_LDAC_EN
        f0 = pulses;
        push(0, 12'h111, 0);
        push(1, 12'h222, 1);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("ldac_pulses", pulses - f0, 1);
        chk("ldac_width", last_w, LDAC_W);
`endif

        for (int i = 0; i < 25; i++) begin
            push($urandom_range(0, 6), $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle();
        chk("err_sticky", err_ch, exp_err);
        chk("queue_drained", exp_q.size(), 0);

        // Reset during bit 7 of a frame with more words waiting in the FIFO.
        push(4, 12'h9C3, 0);
        push(1, 12'h0F0, 0);
        push(2, 12'h00F, 0);
        t = 0;
        while (nb < 8 && t < 500) begin @(posedge clk); #1; t++; end
        chk("bit7_reached", nb >= 8, 1);
        reset = 1'b1;
        exp_q.delete();
        exp_err = 0;
        @(posedge clk); #1;
        chk("midrst_cs_n", cs_n, 3'b111);
        chk("midrst_sck", sck, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", s_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_back", s_ready, 1);
        chk("midrst_err", err_ch, 0);
        f0 = frames;
        repeat (150) @(negedge clk);
        chk("midrst_flushed", frames, f0);
        chk("midrst_idle", busy, 0);
        push(5, 12'h321, 0);
        wait_idle();
        chk("queue_final", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
